mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage RV32I pipeline.
- Captures the MEM-stage result each cycle and extracts and extends load data.
- Selects the writeback source and drives the register file write port (rd, indata, we).
- Also provides bypass data for EX and ID, misaligned-load exception reporting, and a retired-instruction counter.

Parameters:
- XLEN, 32, data and address width.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  the MEM stage holds a real instruction this cycle.
- flush  in  1  discard the incoming instruction; capture a bubble.
- mem_reg_write  in  1  the instruction writes rd.
- mem_rd  in  5  destination register.
- mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- mem_alu  in  XLEN  ALU result; also the load address.
- mem_load_word  in  XLEN  raw aligned word from data memory.
- mem_funct3  in  3  load size and sign.
- mem_pc  in  XLEN  instruction PC.
- id_rs1  in  5  decode-stage source 1, for the bypass compare.
- id_rs2  in  5  decode-stage source 2, for the bypass compare.
- rd  out  5  to the regfile rd.
- indata  out  XLEN  to the regfile indata.
- we  out  1  to the regfile we.
- fwd_valid  out  1  EX bypass: the WB value is valid for fwd_rd.
- fwd_rd  out  5  EX bypass destination.
- fwd_data  out  XLEN  EX bypass data; equals indata.
- byp1_hit  out  1  id_rs1 matches the pending WB write.
- byp2_hit  out  1  id_rs2 matches the pending WB write.
- exc_valid  out  1  misaligned or illegal load retired this cycle.
- exc_pc  out  XLEN  PC of the faulting load.
- exc_addr  out  XLEN  faulting address.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Capture at posedge:
  - reset=1: all state clears.
  - Else flush=1: bubble captured (valid=0). Flush wins over mem_valid.
  - Else: valid<=mem_valid and all mem_* fields are registered.
- Outputs are combinational from the registered fields only. There is no combinational path from mem_* to any output.
- Latency: the MEM value presented before edge N appears on rd/indata/we after edge N. The regfile commits it at edge N+1.
- Load extraction uses offset = alu[1:0]:
  - LB (000): sign-extend the byte at offset.
  - LH (001): sign-extend the half at offset[1].
  - LW (010): whole word.
  - LBU (100): zero-extend the byte at offset.
  - LHU (101): zero-extend the half at offset[1].
- Load faults apply only when wb_sel=01:
  - LH/LHU with offset[0]=1, and LW with offset≠0, are misaligned.
  - funct3 011, 110 and 111 are illegal.
  - Any fault gives exc_valid=1, exc_pc=pc, exc_addr=alu, and indata=0.
  - A fault forces we=0 and is not counted in instret.
- Write enable: we = valid & reg_write & (rd≠0) & !fault. Writes to x0 are never issued.
- Bypass signals:
  - fwd_valid = we; fwd_rd = rd; fwd_data = indata.
  - byp1_hit = we & (id_rs1==rd); byp2_hit = we & (id_rs2==rd).
  - Needed because the regfile write lands at the edge while ID reads the old value combinationally in the same cycle.
- instret: increments by 1 at posedge when valid & !fault. Wraps modulo 2^CNT_W with no saturation.
- exc_valid is high for exactly one cycle per faulting instruction. Back-to-back faults give consecutive pulses.
- Reset values:
  - we=0, rd=0, indata=0, fwd_valid=0, fwd_rd=0, fwd_data=0.
  - byp1_hit=0, byp2_hit=0, exc_valid=0, exc_pc=0, exc_addr=0, instret=0.
- Reset mid-operation: the held instruction is discarded with no write and no count.
- PC+4 is computed here from the registered pc, modulo 2^XLEN.

Decomposition:
- Shared pipeline package holds:
  - WB_ALU/WB_LOAD/WB_PC4/WB_RSVD encodings.
  - F3_LB/LH/LW/LBU/LHU constants.
  - XLEN default.
- One sub-module, load_align: combinational (word, offset, funct3) -> (data, fault). It is reusable by a later store/AMO path.

Test Plan:
1. Reset with instret preloaded by prior traffic -> after one reset cycle instret=0, we=0, exc_valid=0.
2. ALU write:
   - Stimulus: mem_valid=1, reg_write=1, rd=5, wb_sel=00, alu=0xDEADBEEF.
   - Response: next cycle we=1, rd=5, indata=0xDEADBEEF, fwd_valid=1. With id_rs1=5, byp1_hit=1.
   - At the following edge the regfile x5 holds 0xDEADBEEF and instret increments by 1.
3. Load extraction with word=0x80FF7F01:
   - LB off0 -> 0x00000001; LB off3 -> 0xFFFFFF80; LBU off3 -> 0x00000080.
   - LH off2 -> 0xFFFF80FF; LHU off0 -> 0x00007F01.
4. Misaligned load:
   - Stimulus: LW with alu=0x1002, pc=0x40, rd=7.
   - Response: exc_valid=1 for 1 cycle, exc_pc=0x40, exc_addr=0x1002, we=0, instret unchanged.
   - Repeat with funct3=011 -> same fault response.
5. x0 and flush:
   - rd=0 with reg_write=1 -> we=0 but instret increments.
   - flush=1 with mem_valid=1 -> bubble: we=0, no count.
   - flush with reset in the same cycle -> reset state.
6. Counter wrap and PC+4:
   - Stimulus: CNT_W=4, 17 back-to-back valid instructions.
   - Response: instret=1.
   - wb_sel=10 with pc=0xFFFFFFFC -> indata=0x00000000.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline encodings for the writeback stage and its helpers
// Contents: default data width, writeback-source select encodings, load funct3 codes.
package mem_wb_stage_pkg;
    localparam int XLEN_DEF = 32;
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-stage inputs and writeback/bypass/exception outputs of the MEM/WB stage
// Ports: mem_* fields, flush and id_rs1/2 flow into the stage; rd/indata/we, bypass,
// exception and instret flow out. master drives the inputs, slave is the stage itself.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
);
    logic             mem_valid;
    logic             flush;
    logic             mem_reg_write;
    logic [4:0]       mem_rd;
    logic [1:0]       mem_wb_sel;
    logic [XLEN-1:0]  mem_alu;
    logic [XLEN-1:0]  mem_load_word;
    logic [2:0]       mem_funct3;
    logic [XLEN-1:0]  mem_pc;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  indata;
    logic             we;
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic             byp1_hit;
    logic             byp2_hit;
    logic             exc_valid;
    logic [XLEN-1:0]  exc_pc;
    logic [XLEN-1:0]  exc_addr;
    logic [CNT_W-1:0] instret;
    modport master (
        output mem_valid, flush, mem_reg_write, mem_rd, mem_wb_sel, mem_alu,
               mem_load_word, mem_funct3, mem_pc, id_rs1, id_rs2,
        input  rd, indata, we, fwd_valid, fwd_rd, fwd_data, byp1_hit, byp2_hit,
               exc_valid, exc_pc, exc_addr, instret
    );
    modport slave (
        input  mem_valid, flush, mem_reg_write, mem_rd, mem_wb_sel, mem_alu,
               mem_load_word, mem_funct3, mem_pc, id_rs1, id_rs2,
        output rd, indata, we, fwd_valid, fwd_rd, fwd_data, byp1_hit, byp2_hit,
               exc_valid, exc_pc, exc_addr, instret
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align: extracts and extends load data from an aligned word and flags misaligned/illegal loads
// Ports: word_i raw memory word, offset_i byte offset (addr[1:0]), funct3_i load size/sign,
// data_o extended load value (0 for illegal funct3), fault_o misaligned or illegal.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o,
    output logic            fault_o
);
    logic [7:0]  b_v;
    logic [15:0] h_v;
    always_comb begin
        b_v = word_i[{offset_i, 3'b000} +: 8];
        h_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = funct3_i == F3_LB  ? {{(XLEN-8){b_v[7]}}, b_v} :
                 funct3_i == F3_LBU ? {{(XLEN-8){1'b0}}, b_v} :
                 funct3_i == F3_LH  ? {{(XLEN-16){h_v[15]}}, h_v} :
                 funct3_i == F3_LHU ? {{(XLEN-16){1'b0}}, h_v} :
                 funct3_i == F3_LW  ? word_i : '0;
        fault_o = (funct3_i == F3_LB || funct3_i == F3_LBU) ? 1'b0 :
                  (funct3_i == F3_LH || funct3_i == F3_LHU) ? offset_i[0] :
                  funct3_i == F3_LW ? |offset_i : 1'b1;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with writeback select, bypass, load faults and instret
// Ports: clk, reset (sync, active-high); bus (slave) carries the MEM-stage fields in and the
// regfile write port, EX/ID bypass, exception report and retired-instruction count out.
// All outputs derive from registered state only.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);
    logic             valid_q;
    logic             reg_write_q;
    logic [4:0]       rd_q;
    wb_sel_e          wb_sel_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  word_q;
    logic [2:0]       funct3_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic [XLEN-1:0]  load_data;
    logic             align_fault;
    logic             fault;
    logic             we;
    logic [XLEN-1:0]  indata;
    load_align #(.XLEN(XLEN)) u_align (
        .word_i   (word_q),
        .offset_i (alu_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data),
        .fault_o  (align_fault)
    );
    always_comb begin
        fault = valid_q & (wb_sel_q == WB_LOAD) & align_fault;
        we = valid_q & reg_write_q & (|rd_q) & ~fault;
        // reserved select falls through to the ALU result
        indata = fault ? '0 :
                 wb_sel_q == WB_PC4  ? pc_q + XLEN'(4) :
                 wb_sel_q == WB_LOAD ? load_data : alu_q;
        instret_d = (valid_q & ~fault) ? instret_q + CNT_W'(1) : instret_q;
    end
    // the held instruction retires at the same edge the regfile commits it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= WB_ALU;
            alu_q       <= '0;
            word_q      <= '0;
            funct3_q    <= '0;
            pc_q        <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= bus.mem_valid & ~bus.flush;
            reg_write_q <= bus.mem_reg_write;
            rd_q        <= bus.mem_rd;
            wb_sel_q    <= wb_sel_e'(bus.mem_wb_sel);
            alu_q       <= bus.mem_alu;
            word_q      <= bus.mem_load_word;
            funct3_q    <= bus.mem_funct3;
            pc_q        <= bus.mem_pc;
            instret_q   <= instret_d;
        end
    end
    assign bus.rd        = rd_q;
    assign bus.indata    = indata;
    assign bus.we        = we;
    assign bus.fwd_valid = we;
    assign bus.fwd_rd    = rd_q;
    assign bus.fwd_data  = indata;
    assign bus.byp1_hit  = we & (bus.id_rs1 == rd_q);
    assign bus.byp2_hit  = we & (bus.id_rs2 == rd_q);
    assign bus.exc_valid = fault;
    assign bus.exc_pc    = pc_q;
    assign bus.exc_addr  = alu_q;
    assign bus.instret   = instret_q;
endmodule
